// File: rtl/kanagawa_delay_drain_fifo_pkg.sv
// Shared helpers for the Kanagawa delay-drain FIFO consumer stage.
package kanagawa_delay_drain_fifo_pkg;

  // Index width for a DEPTH-entry array; a single-entry array still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/kanagawa_delay_drain_fifo.sv
// Credit-issuing consumer for a fixed-delay pipeline: masks stale arrivals after
// reset, buffers arrivals in a circular store and drains them over ready/valid.
module kanagawa_delay_drain_fifo
  import kanagawa_delay_drain_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DELAY = 4,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  output logic             can_issue_out,
  input  logic             issue_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ready_in,
  output logic             overflow_out
);

  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned MASK_W = $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  credits_used;
  logic [MASK_W-1:0] mask_cnt;

  logic full;
  logic pop;
  logic push_req;
  logic push;
  logic issue_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full     = (count == DEPTH_C);
    pop      = valid_out && ready_in;
    push_req = valid_in && (mask_cnt == '0);
    // A pop frees the slot in the same cycle, so push into a full store is legal then.
    push     = push_req && (!full || pop);
    issue_ok = issue_in && can_issue_out;
  end

  assign can_issue_out = !rst && (credits_used < DEPTH_C);
  assign valid_out     = (count != '0);
  assign data_out      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      credits_used <= '0;
      overflow_out <= 1'b0;
      mask_cnt     <= MASK_W'(DELAY);
    end else begin
      if (mask_cnt != '0) begin
        mask_cnt <= mask_cnt - MASK_W'(1);
      end
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count        <= count + CNT_W'(push) - CNT_W'(pop);
      credits_used <= credits_used + CNT_W'(issue_ok) - CNT_W'(pop);
      if (push_req && full && !pop) begin
        overflow_out <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_kanagawa_delay_drain_fifo.sv
// Scoreboard bench for kanagawa_delay_drain_fifo with an ideal fixed-delay upstream model.
module tb_kanagawa_delay_drain_fifo;

  localparam int WIDTH = 8;
  localparam int DELAY = 4;
  localparam int DEPTH = 5;
  localparam int NCYC  = 4096;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             can_issue_out;
  logic             issue_in = 1'b0;
  logic             valid_in = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             ready_in = 1'b0;
  logic             overflow_out;

  kanagawa_delay_drain_fifo #(.WIDTH(WIDTH), .DELAY(DELAY), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .can_issue_out(can_issue_out),
    .issue_in     (issue_in),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .ready_in     (ready_in),
    .overflow_out (overflow_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Upstream delay line: what was issued in cycle t reappears on valid_in in cycle t+DELAY.
  logic             hv [NCYC];
  logic [WIDTH-1:0] hd [NCYC];

  // Reference model state: expected output order plus occupancy bookkeeping.
  logic [WIDTH-1:0] expq[$];
  int cyc       = 0;
  int unmask    = NCYC;
  int issued    = 0;
  int popped    = 0;
  int stored    = 0;
  bit ovf       = 1'b0;
  logic [WIDTH-1:0] next_data = 8'h10;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Monitor: every handshake pops the scoreboard head.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got=%0h want=none", cyc, data_out);
      end else begin
        logic [WIDTH-1:0] ev;
        ev = expq.pop_front();
        if (data_out !== ev) begin
          errors++;
          $display("FAIL output_data cyc=%0d got=%0h want=%0h", cyc, data_out, ev);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (issue_in && !can_issue_out) begin
      errors++;
      $display("FAIL issue_protocol cyc=%0d got=issue_without_credit want=none", cyc);
    end
  end

  task automatic step(input bit want_issue, input bit rdy, input bit do_rst,
                      input bit force_v, input logic [WIDTH-1:0] force_d);
    bit v;
    bit iss;
    bit exp_can;
    bit pop;
    bit acc;
    logic [WIDTH-1:0] d;
    rst      = do_rst;
    ready_in = rdy && !do_rst;
    v = force_v ? 1'b1 : (cyc >= DELAY ? hv[cyc-DELAY] : 1'b0);
    d = force_v ? force_d : (cyc >= DELAY ? hd[cyc-DELAY] : '0);
    valid_in = v;
    data_in  = d;
    exp_can  = !do_rst && ((issued - popped) < DEPTH);
    iss      = want_issue && exp_can;
    issue_in = iss;
    #1;
    check("can_issue", int'(can_issue_out), int'(exp_can));
    if (!do_rst) begin
      check("valid_out", int'(valid_out), int'(stored > 0));
      check("overflow", int'(overflow_out), int'(ovf));
      if (stored > 0 && expq.size() > 0) check("head_data", int'(data_out), int'(expq[0]));
    end
    hv[cyc] = iss;
    hd[cyc] = next_data;
    if (iss) begin
      expq.push_back(next_data);
      next_data = next_data + 1'b1;
    end
    @(posedge clk);
    pop = (stored > 0) && rdy && !do_rst;
    if (do_rst) begin
      expq.delete();
      issued = 0;
      popped = 0;
      stored = 0;
      ovf    = 1'b0;
      unmask = cyc + 1 + DELAY;
    end else begin
      acc = v && (cyc >= unmask);
      if (iss) issued++;
      if (pop) popped++;
      if (acc) begin
        if (stored < DEPTH || pop) stored++;
        else ovf = 1'b1;
      end
      if (pop) stored--;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      hv[i] = 1'b0;
      hd[i] = '0;
    end
    @(posedge clk);
    #1;
    // Reset, then garbage valid_in through the mask window; one issue at c0.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
    idle(4, 1'b1);
    // Streaming with ready held high.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle(12, 1'b1);
    // Back-pressure until full.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    // Release one entry, then one more issue.
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(14, 1'b1);
    // Fill again, then force arrivals into the full store.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hEF);
    idle(3, 1'b0);
    idle(14, 1'b1);
    // Mid-stream reset with two stored and three in flight.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle(14, 1'b1);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0, 1'b0, '0);
    end
    idle(20, 1'b1);
    check("scoreboard_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
